// File: rtl/sti_pkg.sv
// Shared STI link definitions: length codes, receiver states and word selection.
package sti_pkg;

    localparam int MAX_BITS_DEF = 32;

    typedef enum logic [1:0] {
        LEN8  = 2'd0,
        LEN16 = 2'd1,
        LEN24 = 2'd2,
        LEN32 = 2'd3
    } len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Selects the 16-bit payload from a right-aligned, bit-order-corrected frame.
    function automatic logic [15:0] pick_word(input logic [31:0] raw, input len_t len,
                                              input logic fill, input logic low);
        logic [15:0] w;
        case (len)
            LEN8:    w = low ? {raw[7:0], 8'h00} : {8'h00, raw[7:0]};
            LEN16:   w = raw[15:0];
            LEN24:   w = fill ? raw[23:8] : raw[15:0];
            default: w = fill ? raw[31:16] : raw[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sti_bitrev.sv
// Combinational bit reversal over the low N bits (N = 8/16/24/32 from the length code);
// bits above N come out zero provided the input is zero there.
module sti_bitrev
    import sti_pkg::*;
(
    input  logic [31:0] din,
    input  len_t        len,
    output logic [31:0] dout
);

    logic [31:0] rev;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = din[31-i];
        end
    end

    // Full 32-bit reversal puts the N-bit field at the top; shift it back down.
    always_comb begin
        case (len)
            LEN8:    dout = rev >> 24;
            LEN16:   dout = rev >> 16;
            LEN24:   dout = rev >> 8;
            default: dout = rev;
        endcase
    end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: collects one frame per si_valid burst, measures its length,
// restores bit order and payload placement, and offers the word on a valid/ready port.
module sti_rx
    import sti_pkg::*;
#(
    parameter int MAX_BITS = MAX_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    output logic [15:0] po_data,
    output logic [31:0] po_raw,
    output logic [1:0]  po_length,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        po_err,
    output logic        rx_busy
);

    localparam int CNT_W = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic                msb_q, msb_d, fill_q, fill_d, low_q, low_d;
    logic [15:0]         data_q, data_d;
    logic [31:0]         raw_q, raw_d;
    len_t                len_q, len_d;
    logic                valid_q, valid_d, err_q, err_d, busy_q, busy_d;

    len_t        frame_len;
    logic        frame_legal;
    logic [31:0] rev_raw, fixed_raw;
    logic        frame_end, load, accept;

    sti_bitrev u_bitrev (
        .din  (sh_q[31:0]),
        .len  (frame_len),
        .dout (rev_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            msb_q     <= 1'b0;
            fill_q    <= 1'b0;
            low_q     <= 1'b0;
            data_q    <= '0;
            raw_q     <= '0;
            len_q     <= LEN8;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            msb_q     <= msb_d;
            fill_q    <= fill_d;
            low_q     <= low_d;
            data_q    <= data_d;
            raw_q     <= raw_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (si_valid) state_d = RECV;
            RECV:    if (!si_valid) state_d = IDLE;
                     else if (bit_cnt_q == CNT_MAX) state_d = DRAIN;
            DRAIN:   if (!si_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register, bit counter and per-frame configuration capture.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        msb_d     = msb_q;
        fill_d    = fill_q;
        low_d     = low_q;
        case (state_q)
            IDLE: begin
                if (si_valid) begin
                    sh_d      = {{(MAX_BITS-1){1'b0}}, si_data};
                    bit_cnt_d = CNT_W'(1);
                    msb_d     = cfg_msb;
                    fill_d    = cfg_fill;
                    low_d     = cfg_low;
                end
            end
            RECV: begin
                if (!si_valid) begin
                    bit_cnt_d = '0;
                end else if (bit_cnt_q != CNT_MAX) begin
                    sh_d      = {sh_q[MAX_BITS-2:0], si_data};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DRAIN:   if (!si_valid) bit_cnt_d = '0;
            default: bit_cnt_d = '0;
        endcase
    end

    always_comb begin
        frame_len   = LEN8;
        frame_legal = 1'b1;
        case (bit_cnt_q)
            CNT_W'(8):  frame_len = LEN8;
            CNT_W'(16): frame_len = LEN16;
            CNT_W'(24): frame_len = LEN24;
            CNT_W'(32): frame_len = LEN32;
            default:    frame_legal = 1'b0;
        endcase
    end

    always_comb begin
        fixed_raw = msb_q ? sh_q[31:0] : rev_raw;
        frame_end = (state_q == RECV) && !si_valid;
        accept    = valid_q && po_ready;
        load      = frame_end && frame_legal && (!valid_q || accept);
        data_d    = data_q;
        raw_d     = raw_q;
        len_d     = len_q;
        valid_d   = valid_q;
        if (accept) valid_d = 1'b0;
        if (load) begin
            data_d  = pick_word(fixed_raw, frame_len, fill_q, low_q);
            raw_d   = fixed_raw;
            len_d   = frame_len;
            valid_d = 1'b1;
        end
        // Bad length, overrun and overlength all report on the frame-end edge.
        err_d  = (frame_end && !load) || ((state_q == DRAIN) && !si_valid);
        busy_d = (state_d != IDLE);
    end

    assign po_data   = data_q;
    assign po_raw    = raw_q;
    assign po_length = len_q;
    assign po_valid  = valid_q;
    assign po_err    = err_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: directed scenarios plus randomized frames against a reference model.
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        si_data = 1'b0, si_valid = 1'b0;
    logic        cfg_msb = 1'b0, cfg_fill = 1'b0, cfg_low = 1'b0;
    logic [15:0] po_data;
    logic [31:0] po_raw;
    logic [1:0]  po_length;
    logic        po_valid, po_err, rx_busy;
    logic        po_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    sti_rx dut (
        .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid),
        .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .po_data(po_data), .po_raw(po_raw), .po_length(po_length),
        .po_valid(po_valid), .po_ready(po_ready), .po_err(po_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] msb_seq(input logic [31:0] v, input int n);
        logic [39:0] s = '0;
        for (int i = 0; i < n; i++) s[i] = v[n-1-i];
        return s;
    endfunction

    // Drives one frame (seq[0] first), scrambles cfg after the first bit, then one idle cycle.
    // Returns #1 after the frame-end edge, when the result is visible.
    task automatic send_frame(input logic [39:0] seq, input int n, input logic msb,
                              input logic fill, input logic low, input logic rdy_end);
        po_ready = 1'b0;
        cfg_msb = msb; cfg_fill = fill; cfg_low = low;
        for (int i = 0; i < n; i++) begin
            si_valid = 1'b1;
            si_data  = seq[i];
            @(posedge clk); #1;
            if (i == 0) begin
                cfg_msb  = 1'($urandom_range(0, 1));
                cfg_fill = 1'($urandom_range(0, 1));
                cfg_low  = 1'($urandom_range(0, 1));
            end
        end
        si_valid = 1'b0; si_data = 1'b0;
        po_ready = rdy_end;
        @(posedge clk); #1;
    endtask

    task automatic flush();
        po_ready = 1'b1;
        @(posedge clk); #1;
        po_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({po_data, po_raw, po_length} !== 50'd0) begin errors++;
            $display("FAIL reset_data: got %h/%h/%0d want 0", po_data, po_raw, po_length); end
        checks++; if ({po_valid, po_err, rx_busy} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got v%b e%b b%b want 000", po_valid, po_err, rx_busy); end
    endtask

    task automatic test_directed();
        send_frame(msb_seq(32'hA5C3, 16), 16, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if ({po_valid, po_err, rx_busy} !== 3'b100) begin errors++;
            $display("FAIL d16_flags: got v%b e%b b%b want 100", po_valid, po_err, rx_busy); end
        checks++; if (po_data !== 16'hA5C3 || po_length !== 2'd1) begin errors++;
            $display("FAIL d16_word: got %h len %0d want a5c3 len 1", po_data, po_length); end
        @(posedge clk); #1;
        checks++; if (po_valid !== 1'b0) begin errors++;
            $display("FAIL d16_one_cycle: po_valid %b want 0", po_valid); end

        send_frame(40'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (po_raw !== 32'h1 || po_data !== 16'h0100 || po_length !== 2'd0) begin errors++;
            $display("FAIL d8_low: got raw %h data %h len %0d want 1/0100/0", po_raw, po_data, po_length); end
        flush();

        send_frame(msb_seq(32'h123400, 24), 24, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (po_data !== 16'h1234 || po_length !== 2'd2) begin errors++;
            $display("FAIL d24_fill: got %h len %0d want 1234 len 2", po_data, po_length); end
        flush();
        send_frame(msb_seq(32'h001234, 24), 24, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_data !== 16'h1234) begin errors++;
            $display("FAIL d24_nofill: got %h want 1234", po_data); end
        flush();
        send_frame(msb_seq(32'hBEEF0000, 32), 32, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (po_data !== 16'hBEEF || po_raw !== 32'hBEEF0000 || po_length !== 2'd3) begin errors++;
            $display("FAIL d32_fill: got %h raw %h len %0d want beef", po_data, po_raw, po_length); end
        flush();
    endtask

    task automatic test_bad_length();
        send_frame(40'hABC, 12, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_err !== 1'b1 || po_valid !== 1'b0) begin errors++;
            $display("FAIL bad12: err %b valid %b want 1 0", po_err, po_valid); end
        @(posedge clk); #1;
        checks++; if (po_err !== 1'b0) begin errors++;
            $display("FAIL bad12_pulse: err %b want 0", po_err); end
        send_frame(40'hFF_FFFF_FFFF, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_err !== 1'b1 || po_valid !== 1'b0 || rx_busy !== 1'b0) begin errors++;
            $display("FAIL bad40: err %b valid %b busy %b want 1 0 0", po_err, po_valid, rx_busy); end
        send_frame(msb_seq(32'h5A3C, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_valid !== 1'b1 || po_err !== 1'b0 || po_data !== 16'h5A3C) begin errors++;
            $display("FAIL after_bad: v%b e%b data %h want 1 0 5a3c", po_valid, po_err, po_data); end
        flush();
    endtask

    task automatic test_backpressure();
        send_frame(msb_seq(32'h1111, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(msb_seq(32'h2222, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_err !== 1'b1 || po_valid !== 1'b1 || po_data !== 16'h1111) begin errors++;
            $display("FAIL overrun: e%b v%b data %h want 1 1 1111", po_err, po_valid, po_data); end
        @(posedge clk); #1;
        checks++; if (po_err !== 1'b0 || po_data !== 16'h1111) begin errors++;
            $display("FAIL overrun_hold: e%b data %h want 0 1111", po_err, po_data); end
        flush();
        send_frame(msb_seq(32'h3333, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(msb_seq(32'h4444, 16), 16, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (po_err !== 1'b0 || po_valid !== 1'b1 || po_data !== 16'h4444) begin errors++;
            $display("FAIL accept_reload: e%b v%b data %h want 0 1 4444", po_err, po_valid, po_data); end
        flush();
    endtask

    task automatic test_reset_midframe();
        send_frame(msb_seq(32'h7777, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            si_valid = 1'b1; si_data = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (rx_busy !== 1'b1) begin errors++;
            $display("FAIL busy_mid: rx_busy %b want 1", rx_busy); end
        reset = 1'b1;
        #2;
        checks++; if ({po_data, po_raw, po_length, po_valid, po_err, rx_busy} !== 53'd0) begin errors++;
            $display("FAIL reset_mid: data %h raw %h v%b e%b b%b want all 0", po_data, po_raw, po_valid, po_err, rx_busy); end
        si_valid = 1'b0; si_data = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        send_frame(msb_seq(32'h00FF, 16), 16, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (po_valid !== 1'b1 || po_data !== 16'h00FF || po_err !== 1'b0) begin errors++;
            $display("FAIL after_reset: v%b data %h e%b want 1 00ff 0", po_valid, po_data, po_err); end
        flush();
    endtask

    task automatic test_random();
        logic        mvalid = 1'b0;
        logic [15:0] mdata = '0;
        logic [31:0] mraw = '0;
        logic [1:0]  mlen = '0;
        for (int k = 0; k < 60; k++) begin
            int          n;
            logic [63:0] r;
            logic [39:0] seq;
            logic        msb, fill, low, rdy, legal, eerr, acc;
            logic [63:0] raw, d;
            n = ($urandom_range(0, 9) < 7) ? 8 * $urandom_range(1, 4) : $urandom_range(1, 40);
            r = {$urandom, $urandom};
            seq = r[39:0];
            msb = 1'($urandom_range(0, 1)); fill = 1'($urandom_range(0, 1));
            low = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
            raw = '0;
            for (int i = 0; i < n && i < 32; i++) begin
                if (msb) raw[n-1-i] = seq[i];
                else     raw[i] = seq[i];
            end
            if (n == 8) d = low ? raw << 8 : raw;
            else        d = (fill && n > 16) ? raw >> (n - 16) : raw;
            legal = (n % 8 == 0) && (n <= 32);
            acc = mvalid && rdy;
            eerr = 1'b0;
            if (legal && (!mvalid || acc)) begin
                mvalid = 1'b1; mdata = d[15:0]; mraw = raw[31:0]; mlen = 2'(n / 8 - 1);
            end else begin
                eerr = 1'b1;
                if (acc) mvalid = 1'b0;
            end
            send_frame(seq, n, msb, fill, low, rdy);
            checks++; if (po_valid !== mvalid || po_err !== eerr) begin errors++;
                $display("FAIL rnd%0d_flags n=%0d: v%b e%b want v%b e%b", k, n, po_valid, po_err, mvalid, eerr); end
            if (mvalid) begin
                checks++; if (po_data !== mdata || po_raw !== mraw || po_length !== mlen) begin errors++;
                    $display("FAIL rnd%0d_word n=%0d: %h/%h/%0d want %h/%h/%0d", k, n,
                             po_data, po_raw, po_length, mdata, mraw, mlen); end
            end
            if ($urandom_range(0, 1) == 1) begin
                po_ready = 1'b1;
                @(posedge clk); #1;
                po_ready = 1'b0;
                mvalid = 1'b0;
                checks++; if (po_valid !== 1'b0 || po_err !== 1'b0) begin errors++;
                    $display("FAIL rnd%0d_drain: v%b e%b want 0 0", k, po_valid, po_err); end
            end
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bad_length();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sti_rx.md
# sti_rx

Serial receiver for the STI link: the far end of the serial transmitter's `so_data`/`so_valid` pair.
- Captures one frame per burst of `si_valid`.
- Measures the frame length, undoes the transmitter's bit-order and fill/low placement, and presents the recovered 16-bit word on a valid/ready output port.
- Sits between the serial link and the downstream checker/DMA logic.

## Interface
Parameters:
- MAX_BITS, 32, longest legal frame; the shift register is MAX_BITS wide.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- si_data  in  1  serial data bit, sampled on every edge where `si_valid`=1.
- si_valid  in  1  frame envelope; high for consecutive cycles, one bit per cycle.
- cfg_msb  in  1  1: first received bit is the frame MSB; 0: first bit is the LSB.
- cfg_fill  in  1  24/32-bit frames. 1: payload is the upper 16 bits (zeros in the LSBs). 0: payload is the lower 16 bits.
- cfg_low  in  1  8-bit frames. 1: byte goes to `po_data[15:8]`. 0: byte goes to `po_data[7:0]`. The other byte is zero.
- po_data  out  16  recovered word.
- po_raw  out  32  bit-order-corrected frame, right-aligned, zero-extended.
- po_length  out  2  0/1/2/3 = 8/16/24/32-bit frame.
- po_valid  out  1  output word available.
- po_ready  in  1  consumer accepts; a transfer happens on an edge where `po_valid`&&`po_ready`.
- po_err  out  1  one-cycle pulse: bad length or overrun.
- rx_busy  out  1  frame reception in progress.

## Operation
- States:
  - IDLE: waiting for a frame.
  - RECV: collecting bits.
  - DRAIN: overlength frame; discarding bits until `si_valid`=0.
- IDLE -> RECV on an edge with `si_valid`=1:
  - Sample `cfg_*` into registers; they hold for the whole frame.
  - Store the first bit; `bit_cnt`=1.
- RECV with `si_valid`=1: shift left, new bit into the LSB, `bit_cnt`+1.
  - If `bit_cnt` is already MAX_BITS, go to DRAIN instead.
- RECV with `si_valid`=0 (frame end):
  - `bit_cnt` in {8,16,24,32}: frame is legal. Build the word and go to IDLE.
  - Any other `bit_cnt`: pulse `po_err`, discard, go to IDLE.
- DRAIN: ignore bits. On `si_valid`=0, pulse `po_err` and go to IDLE.
- Word build for N = `bit_cnt`:
  - raw = shift register [N-1:0], bit-reversed over N bits when latched `cfg_msb`=0.
  - `po_length` = N/8 - 1.
  - N=16: `po_data` = raw[15:0].
  - N=24: `po_data` = raw[23:8] if fill, else raw[15:0].
  - N=32: `po_data` = raw[31:16] if fill, else raw[15:0].
  - N=8: `po_data` = {raw[7:0], 8'h00} if low, else {8'h00, raw[7:0]}.
- Output buffer is a single register set, separate from the shift register, so the next frame can arrive while a word is held.
  - The buffer loads on a legal frame end if `po_valid`=0, or if `po_valid`&&`po_ready` on that same edge (accept and reload simultaneously).
  - Otherwise it is an overrun: the new frame is dropped, `po_err` pulses, and the held word is unchanged.
- `po_valid` clears on accept unless reloaded on the same edge.
- A new frame may start on the edge immediately after a frame end. `si_valid` low for one cycle is a sufficient gap.
- Reset mid-frame: partial frame lost; state IDLE; nothing emitted.

## Timing
- Reset values:
  - `po_data`, `po_raw`, `po_length` = 0.
  - `po_valid`, `po_err`, `rx_busy` = 0.
  - State IDLE, `bit_cnt` = 0.
- Latency: `po_valid` rises in the cycle after the first `si_valid`=0 cycle following the last bit, i.e. 2 cycles after the last bit is presented.
- `po_err` goes high for exactly one cycle, in that same cycle after the frame end.
- `rx_busy` = 1 while the state is RECV or DRAIN. It is registered and aligned with the state.
- `po_*` hold steady while `po_valid`=1 and `po_ready`=0.
- `po_ready` is ignored while `po_valid`=0.

## Structure
- Shared package `sti_pkg`:
  - Length codes LEN8/LEN16/LEN24/LEN32 = 0..3.
  - State enum IDLE/RECV/DRAIN.
  - MAX_BITS default.
- One natural sub-module, `sti_bitrev`: combinational N-bit reversal selected by the length code. It is reusable by the transmitter side.
- Everything else stays in `sti_rx`.

## Test plan
- 16-bit, cfg_msb=1:
  - Stimulus: bits 1010_0101_1100_0011, then `si_valid` low, `po_ready`=1.
  - Response: `po_data`=0xA5C3, `po_length`=1, one `po_valid` cycle.
- 8-bit, cfg_msb=0, cfg_low=1:
  - Stimulus: bits 1,0,0,0,0,0,0,0.
  - Response: `po_raw`=0x01, `po_data`=0x0100, `po_length`=0.
- 24-bit, msb-first raw 0x123400:
  - fill=1 -> `po_data`=0x1234.
  - raw 0x001234 with fill=0 -> `po_data`=0x1234.
  - 32-bit raw 0xBEEF0000 with fill=1 -> 0xBEEF.
- Bad lengths:
  - 12-bit frame -> `po_err` pulse, no `po_valid`.
  - 40-bit frame -> DRAIN, `po_err` pulse after `si_valid` drops.
  - The next good frame is received correctly.
- Backpressure:
  - Hold `po_ready`=0 across two back-to-back 16-bit frames -> first word retained, `po_err` on the second.
  - Repeat with `po_ready`=1 on the second frame-end edge -> second word loaded, no error.
- Reset mid-frame:
  - Assert reset after 5 bits -> all outputs 0.
  - A following 16-bit frame 0x00FF is received correctly.
